uart_apb_csr: RTL and testbench

UART_APB_CSR -- requirements
Module: uart_apb_csr

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_apb_csr.sv | 189 ++++++++++++++++++
 tb/tb_uart_apb_csr.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, control/status bit positions and TX FSM encoding for the
// UART APB register block.
package uart_pkg;

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h01;
  localparam logic [7:0] ADDR_BAUD   = 8'h02;
  localparam logic [7:0] ADDR_CTRL0  = 8'h03;
  localparam logic [7:0] ADDR_CTRL1  = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h05;
  localparam logic [7:0] ADDR_LEVEL  = 8'h06;

  localparam int C0_TXEN  = 0;
  localparam int C0_RXEN  = 1;
  localparam int C0_TXIE  = 2;
  localparam int C0_RXIE  = 3;
  localparam int C0_ERRIE = 4;
  localparam int C0_LOOP  = 5;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXIDLE = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_FE     = 3;
  localparam int ST_PE     = 4;
  localparam int ST_TXOVR  = 5;
  localparam int ST_TXFULL = 6;
  localparam int ST_RXFULL = 7;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;

  // LEVEL fields are 8 bits wide; a 256-deep FIFO that is full reports 0xFF.
  function automatic logic [7:0] level8(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO used for the UART TX and RX character queues. A push into a
// full FIFO is accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign count   = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~empty;
  assign w_push  = i_push & (~full | w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the storage is flop-based and cleared along with the pointers, so no
  // character from before a reset can ever be observed afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_csr.sv
// APB register block for a UART: TX/RX FIFOs, frame launch FSM, sticky error
// status and interrupt. Define UART_APB_CSR_LOOPBACK_EN to build TX->RX loopback.
module uart_apb_csr
  import uart_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RST   = 16'd0
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [7:0]        pAddr,
  input  logic [31:0]       pWdata,
  output logic [31:0]       pReadData,
  output logic              TxStart,
  output logic [DATA_W-1:0] TxData,
  input  logic              TxDone,
  input  logic              RxDone,
  input  logic [DATA_W-1:0] RxData,
  input  logic              RxStopBit,
  input  logic              RxParityErr,
  output logic [15:0]       Baud,
  output logic [4:0]        Cfg,
  output logic              IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]       r_baud;
  logic [4:0]        r_ctrl0;
  logic [4:0]        r_ctrl1;
  logic              r_ovr, r_fe, r_pe, r_txovr;
  logic              r_rxdone_q;
  logic              r_irq;
  logic [DATA_W-1:0] r_tx_data;
  tx_state_e         r_state, w_next;

  logic              w_wr_acc, w_rd_acc, w_loop;
  logic              w_tx_push_req, w_tx_pop, w_tx_empty, w_tx_full, w_lb_push;
  logic [DATA_W-1:0] w_tx_rdata;
  logic [CW-1:0]     w_tx_count, w_rx_count;
  logic              w_rx_evt, w_rx_pop, w_rx_empty, w_rx_full, w_rx_fe, w_rx_pe;
  logic [DATA_W-1:0] w_rx_char, w_rx_rdata;
  logic              w_rxdone_rise, w_txidle, w_st_wr;
  logic [7:0]        w_status;
  logic              w_unused;

  assign w_wr_acc      = pSel & pEnable & pWrite;
  assign w_rd_acc      = pSel & pEnable & ~pWrite;
  assign w_tx_push_req = w_wr_acc & (pAddr == ADDR_TXDATA);
  assign w_rx_pop      = w_rd_acc & (pAddr == ADDR_RXDATA) & ~w_rx_empty;
  assign w_st_wr       = w_wr_acc & (pAddr == ADDR_STATUS);
  assign w_rxdone_rise = RxDone & ~r_rxdone_q;
  assign w_txidle      = (r_state == TX_IDLE) & w_tx_empty;
  assign w_unused      = &{1'b0, pWdata[31:16]};

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(pClk), .rst_n(pReset), .i_push(w_tx_push_req), .i_wdata(pWdata[DATA_W-1:0]),
    .i_pop(w_tx_pop), .o_rdata(w_tx_rdata), .empty(w_tx_empty), .full(w_tx_full),
    .count(w_tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(pClk), .rst_n(pReset), .i_push(w_rx_evt), .i_wdata(w_rx_char),
    .i_pop(w_rx_pop), .o_rdata(w_rx_rdata), .empty(w_rx_empty), .full(w_rx_full),
    .count(w_rx_count)
  );

`ifdef UART_APB_CSR_LOOPBACK_EN
  logic r_loop;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset)                                r_loop <= 1'b0;
    else if (w_wr_acc && pAddr == ADDR_CTRL0)   r_loop <= pWdata[C0_LOOP];
  end

  // While looping, the external deserializer is ignored and the launched
  // character is received as a clean frame.
  assign w_loop    = r_loop;
  assign w_rx_evt  = r_ctrl0[C0_RXEN] & (w_loop ? w_lb_push : w_rxdone_rise);
  assign w_rx_char = w_loop ? r_tx_data : RxData;
  assign w_rx_fe   = ~w_loop & ~RxStopBit;
  assign w_rx_pe   = ~w_loop & RxParityErr;
`else
  assign w_loop    = 1'b0;
  assign w_rx_evt  = r_ctrl0[C0_RXEN] & w_rxdone_rise;
  assign w_rx_char = RxData;
  assign w_rx_fe   = ~RxStopBit;
  assign w_rx_pe   = RxParityErr;
`endif

  // TX launch FSM: state register, next-state logic, outputs.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) r_state <= TX_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      TX_IDLE: if (r_ctrl0[C0_TXEN] && !w_tx_empty) w_next = TX_LOAD;
      TX_LOAD: w_next = w_loop ? TX_IDLE : TX_BUSY;
      TX_BUSY: if (TxDone) w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop  = (r_state == TX_IDLE) & r_ctrl0[C0_TXEN] & ~w_tx_empty;
    TxStart   = (r_state == TX_LOAD) & ~w_loop;
    w_lb_push = (r_state == TX_LOAD) & w_loop;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_baud     <= BAUD_RST;
      r_ctrl0    <= '0;
      r_ctrl1    <= '0;
      r_tx_data  <= '0;
      r_rxdone_q <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_acc && pAddr == ADDR_BAUD)  r_baud  <= pWdata[15:0];
      if (w_wr_acc && pAddr == ADDR_CTRL0) r_ctrl0 <= pWdata[4:0];
      if (w_wr_acc && pAddr == ADDR_CTRL1) r_ctrl1 <= pWdata[4:0];
      if (w_tx_pop)                        r_tx_data <= w_tx_rdata;
      r_rxdone_q <= RxDone;
      r_irq      <= (r_ctrl0[C0_RXIE] & ~w_rx_empty) | (r_ctrl0[C0_TXIE] & w_txidle) |
                    (r_ctrl0[C0_ERRIE] & (r_ovr | r_fe | r_pe | r_txovr));
    end
  end

  // Sticky errors: a set in the same cycle as its W1C wins.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      r_ovr   <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_txovr <= 1'b0;
    end else begin
      r_ovr   <= (r_ovr   & ~(w_st_wr & pWdata[ST_OVR]))   | (w_rx_evt & w_rx_full & ~w_rx_pop);
      r_fe    <= (r_fe    & ~(w_st_wr & pWdata[ST_FE]))    | (w_rx_evt & w_rx_fe);
      r_pe    <= (r_pe    & ~(w_st_wr & pWdata[ST_PE]))    | (w_rx_evt & w_rx_pe);
      r_txovr <= (r_txovr & ~(w_st_wr & pWdata[ST_TXOVR])) | (w_tx_push_req & w_tx_full & ~w_tx_pop);
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[ST_RXNE]    = ~w_rx_empty;
    w_status[ST_TXIDLE]  = w_txidle;
    w_status[ST_OVR]     = r_ovr;
    w_status[ST_FE]      = r_fe;
    w_status[ST_PE]      = r_pe;
    w_status[ST_TXOVR]   = r_txovr;
    w_status[ST_TXFULL]  = w_tx_full;
    w_status[ST_RXFULL]  = w_rx_full;
  end

  always_comb begin
    pReadData = '0;
    case (pAddr)
      ADDR_RXDATA: if (!w_rx_empty) pReadData[DATA_W-1:0] = w_rx_rdata;
      ADDR_BAUD:   pReadData[15:0] = r_baud;
      ADDR_CTRL0: begin
        pReadData[4:0]     = r_ctrl0;
        pReadData[C0_LOOP] = w_loop;
      end
      ADDR_CTRL1:  pReadData[4:0] = r_ctrl1;
      ADDR_STATUS: pReadData[7:0] = w_status;
      ADDR_LEVEL: begin
        pReadData[23:16] = level8(9'(w_rx_count));
        pReadData[7:0]   = level8(9'(w_tx_count));
      end
      default: pReadData = '0;
    endcase
  end

  assign TxData = r_tx_data;
  assign Baud   = r_baud;
  assign Cfg    = r_ctrl1;
  assign IRQ    = r_irq;

endmodule

// File: tb/tb_uart_apb_csr.sv
// Self-checking bench for uart_apb_csr: register table, TX/RX scoreboards and
// hand-written multi-cycle sequences (loopback sequence when the macro is defined).
module tb_uart_apb_csr;

  localparam int          DEPTH    = 16;
  localparam logic [15:0] BAUD_RV  = 16'h1A2B;
  localparam int          DONE_DLY = 8;
`ifdef UART_APB_CSR_LOOPBACK_EN
  localparam logic [31:0] C0_RB = 32'h3F;
`else
  localparam logic [31:0] C0_RB = 32'h1F;
`endif

  logic        pClk = 1'b0;
  logic        pReset, pSel, pEnable, pWrite;
  logic [7:0]  pAddr;
  logic [31:0] pWdata, pReadData;
  logic        TxStart, TxDone, RxDone, RxStopBit, RxParityErr, IRQ;
  logic [7:0]  TxData, RxData;
  logic [15:0] Baud;
  logic [4:0]  Cfg;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tx_starts = 0;
  logic        tx_busy = 1'b0;
  int          tx_cnt  = 0;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  logic [31:0] got;
  int          base;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  always #5 pClk = ~pClk;

  uart_apb_csr #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .BAUD_RST(BAUD_RV)) dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData), .TxStart(TxStart),
    .TxData(TxData), .TxDone(TxDone), .RxDone(RxDone), .RxData(RxData),
    .RxStopBit(RxStopBit), .RxParityErr(RxParityErr), .Baud(Baud), .Cfg(Cfg), .IRQ(IRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge pClk); pSel = 1; pEnable = 0; pWrite = 1; pAddr = a; pWdata = d;
    @(negedge pClk); pEnable = 1;
    @(negedge pClk); pSel = 0; pEnable = 0; pWrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge pClk); pSel = 1; pEnable = 0; pWrite = 0; pAddr = a;
    @(negedge pClk); pEnable = 1;
    #1 d = pReadData;
    @(negedge pClk); pSel = 0; pEnable = 0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic rx_read_check(input string name);
    logic [31:0] d;
    apb_read(8'h01, d);
    if (rx_exp.size() > 0) check(name, d, {24'h0, rx_exp.pop_front()});
    else                   check(name, d, 32'h0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic perr);
    @(negedge pClk); RxData = d; RxStopBit = stop; RxParityErr = perr; RxDone = 1;
    @(negedge pClk); RxDone = 0; RxStopBit = 1; RxParityErr = 0;
    @(negedge pClk);
  endtask

  task automatic do_reset();
    @(negedge pClk);
    pReset = 0; pSel = 0; pEnable = 0; pWrite = 0; RxDone = 0;
    tx_exp.delete();
    rx_exp.delete();
    repeat (3) @(negedge pClk);
    pReset = 1;
  endtask

  task automatic wait_starts(input string name, input int n);
    for (int k = 0; k < 200 && tx_starts < n; k++) @(negedge pClk);
    check(name, tx_starts, n);
  endtask

  task automatic wait_tx_drain(input string name);
    for (int k = 0; k < 400 && (tx_busy || tx_exp.size() != 0); k++) @(negedge pClk);
    check(name, tx_exp.size(), 0);
    repeat (3) @(negedge pClk);
  endtask

  // Serializer model: scores every launch against the TX queue, then answers
  // with a TxDone pulse DONE_DLY cycles later.
  initial begin
    TxDone = 0;
    forever begin
      @(negedge pClk);
      TxDone = 0;
      if (!pReset) begin
        tx_busy = 0;
        tx_cnt  = 0;
      end else if (TxStart) begin
        tx_starts++;
        check("tx_start_while_busy", {31'h0, tx_busy}, 32'h0);
        if (tx_exp.size() == 0) check("tx_start_expected", 32'h1, 32'h0);
        else                    check("tx_data", {24'h0, TxData}, {24'h0, tx_exp.pop_front()});
        tx_busy = 1;
        tx_cnt  = DONE_DLY;
      end else if (tx_busy) begin
        if (tx_cnt == 0) begin
          TxDone  = 1;
          tx_busy = 0;
        end else tx_cnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset = 0; pSel = 0; pEnable = 0; pWrite = 0; pAddr = 0; pWdata = 0;
    RxDone = 0; RxData = 0; RxStopBit = 1; RxParityErr = 0;

    vecs[0]  = '{1'b0, 8'h02, 32'h0,         {16'h0, BAUD_RV}};
    vecs[1]  = '{1'b0, 8'h05, 32'h0,         32'h02};
    vecs[2]  = '{1'b0, 8'h06, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 8'h03, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 8'h01, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 8'h02, 32'hDEADBEEF,  32'h0};
    vecs[6]  = '{1'b0, 8'h02, 32'h0,         32'hBEEF};
    vecs[7]  = '{1'b1, 8'h04, 32'hFFFFFFFF,  32'h0};
    vecs[8]  = '{1'b0, 8'h04, 32'h0,         32'h1F};
    vecs[9]  = '{1'b1, 8'h03, 32'h3F,        32'h0};
    vecs[10] = '{1'b0, 8'h03, 32'h0,         C0_RB};
    vecs[11] = '{1'b1, 8'h07, 32'hFFFF,      32'h0};
    vecs[12] = '{1'b0, 8'h07, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 8'h40, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 8'h03, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 8'h03, 32'h0,         32'h0};

    do_reset();
    @(negedge pClk);
    check("irq_reset", {31'h0, IRQ}, 32'h0);
    check("txstart_reset", {31'h0, TxStart}, 32'h0);
    check("txdata_reset", {24'h0, TxData}, 32'h0);
    check("baud_out_reset", {16'h0, Baud}, {16'h0, BAUD_RV});
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else begin
        apb_read(vecs[i].addr, got);
        check($sformatf("reg_vec%0d", i), got, vecs[i].exp);
      end
    end
    check("baud_out", {16'h0, Baud}, 32'hBEEF);
    check("cfg_out", {27'h0, Cfg}, 32'h1F);

    // Two characters, each launched only after the previous TxDone.
    do_reset();
    base = tx_starts;
    apb_write(8'h03, 32'h01);
    tx_exp.push_back(8'h41); apb_write(8'h00, 32'h41);
    tx_exp.push_back(8'h42); apb_write(8'h00, 32'h42);
    wait_starts("tx_two_starts", base + 2);
    wait_tx_drain("tx_two_drain");
    check("tx_two_count", tx_starts - base, 32'd2);
    read_check("tx_two_status_idle", 8'h05, 32'h02);

    // TXEN cleared mid-frame: the frame completes, the queued one stays put.
    do_reset();
    base = tx_starts;
    apb_write(8'h03, 32'h01);
    tx_exp.push_back(8'h11); apb_write(8'h00, 32'h11);
    apb_write(8'h00, 32'h22);
    apb_write(8'h03, 32'h00);
    wait_tx_drain("txen_off_drain");
    repeat (20) @(negedge pClk);
    check("txen_off_one_start", tx_starts - base, 32'd1);
    read_check("txen_off_level", 8'h06, 32'h01);
    read_check("txen_off_status", 8'h05, 32'h00);

    // TX overflow with the launcher disabled.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) apb_write(8'h00, 32'h30 + i);
    read_check("txovr_level", 8'h06, 32'h10);
    read_check("txovr_status", 8'h05, 32'h60);
    apb_write(8'h05, 32'h20);
    read_check("txovr_w1c", 8'h05, 32'h40);

    // RX overflow, drain, empty read.
    do_reset();
    apb_write(8'h03, 32'h02);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (rx_exp.size() < DEPTH) rx_exp.push_back(8'(i));
      rx_frame(8'(i), 1'b1, 1'b0);
    end
    read_check("rx_ovr_status", 8'h05, 32'h87);
    for (int i = 0; i < DEPTH; i++) rx_read_check($sformatf("rx_data%0d", i));
    read_check("rx_empty_read", 8'h01, 32'h0);
    read_check("rx_drained_status", 8'h05, 32'h06);
    apb_write(8'h05, 32'h04);
    for (int i = 0; i < DEPTH; i++) begin
      rx_exp.push_back(8'h80 + 8'(i));
      rx_frame(8'h80 + 8'(i), 1'b1, 1'b0);
    end
    // Pop and push into a full RX FIFO in the same cycle.
    @(negedge pClk); pSel = 1; pEnable = 0; pWrite = 0; pAddr = 8'h01;
    @(negedge pClk); pEnable = 1; RxData = 8'hAA; RxDone = 1; RxStopBit = 1;
    #1 got = pReadData;
    @(negedge pClk); pSel = 0; pEnable = 0; RxDone = 0;
    check("rx_coincident_pop", got, {24'h0, rx_exp.pop_front()});
    rx_exp.push_back(8'hAA);
    read_check("rx_coincident_level", 8'h06, 32'h00100000);
    read_check("rx_coincident_status", 8'h05, 32'h83);

    // Framing error, IRQ latency, W1C racing a new bad frame, parity error.
    do_reset();
    apb_write(8'h03, 32'h12);
    @(negedge pClk); RxData = 8'h55; RxStopBit = 0; RxDone = 1;
    rx_exp.push_back(8'h55);
    @(posedge pClk); #1;
    check("fe_irq_not_yet", {31'h0, IRQ}, 32'h0);
    @(posedge pClk); #1;
    check("fe_irq_next", {31'h0, IRQ}, 32'h1);
    @(negedge pClk); RxDone = 0; RxStopBit = 1;
    read_check("fe_status", 8'h05, 32'h0B);
    @(negedge pClk); pSel = 1; pEnable = 0; pWrite = 1; pAddr = 8'h05; pWdata = 32'h08;
    @(negedge pClk); pEnable = 1; RxData = 8'h66; RxStopBit = 0; RxDone = 1;
    rx_exp.push_back(8'h66);
    @(negedge pClk); pSel = 0; pEnable = 0; pWrite = 0; RxDone = 0; RxStopBit = 1;
    read_check("fe_w1c_race_status", 8'h05, 32'h0B);
    check("fe_w1c_race_irq", {31'h0, IRQ}, 32'h1);
    apb_write(8'h05, 32'h08);
    read_check("fe_cleared_status", 8'h05, 32'h03);
    check("fe_cleared_irq", {31'h0, IRQ}, 32'h0);
    rx_exp.push_back(8'h77);
    rx_frame(8'h77, 1'b1, 1'b1);
    read_check("pe_status", 8'h05, 32'h13);
    check("pe_irq", {31'h0, IRQ}, 32'h1);
    for (int i = 0; i < 3; i++) rx_read_check($sformatf("err_rx_data%0d", i));

    // Reset in the middle of a frame abandons it.
    do_reset();
    base = tx_starts;
    apb_write(8'h03, 32'h01);
    tx_exp.push_back(8'h77); apb_write(8'h00, 32'h77);
    apb_write(8'h00, 32'h78);
    wait_starts("rst_mid_start", base + 1);
    do_reset();
    #1;
    check("rst_mid_txdata", {24'h0, TxData}, 32'h0);
    check("rst_mid_txstart", {31'h0, TxStart}, 32'h0);
    apb_write(8'h03, 32'h01);
    repeat (20) @(negedge pClk);
    check("rst_mid_no_restart", tx_starts - base, 32'd1);
    read_check("rst_mid_status", 8'h05, 32'h02);
    read_check("rst_mid_level", 8'h06, 32'h0);

`ifdef UART_APB_CSR_LOOPBACK_EN
    do_reset();
    base = tx_starts;
    apb_write(8'h03, 32'h23);
    rx_exp.push_back(8'h5A);
    apb_write(8'h00, 32'h5A);
    repeat (6) @(negedge pClk);
    check("loop_no_txstart", tx_starts - base, 32'd0);
    rx_read_check("loop_rx_data");
    read_check("loop_status", 8'h05, 32'h02);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
